// File: rtl/ann_fixed_pkg.sv
// Shared Q8.24 fixed-point definitions for the ANN datapath blocks
// (perceptron, sigmoid_act, backprop).
package ann_fixed_pkg;

    localparam int WIDTH = 32;
    localparam int FRAC  = 24;

    localparam logic signed [WIDTH-1:0] ONE      = 1 << FRAC;
    localparam logic signed [WIDTH-1:0] Q_HALF   = ONE >>> 1;
    localparam logic signed [WIDTH-1:0] Q_0625   = (ONE >>> 3) * 5;
    localparam logic signed [WIDTH-1:0] Q_084375 = (ONE >>> 5) * 27;

    // Sigmoid PLAN breakpoints: 1.0, 2.375 and 5.0
    localparam logic signed [WIDTH-1:0] BP_1    = ONE;
    localparam logic signed [WIDTH-1:0] BP_2375 = (ONE >>> 3) * 19;
    localparam logic signed [WIDTH-1:0] BP_5    = ONE * 5;

    typedef enum logic [1:0] {
        SEG_0 = 2'd0,
        SEG_1 = 2'd1,
        SEG_2 = 2'd2,
        SEG_3 = 2'd3
    } seg_t;

endpackage

// File: rtl/fxp_mult.sv
// Signed fixed-point multiply: full-width product, result truncated back to
// WIDTH bits with FRAC fractional bits.
module fxp_mult #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] p
);

    logic signed [2*WIDTH-1:0] full;

    assign full = a * b;
    assign p    = WIDTH'(full >>> FRAC);

endmodule

// File: rtl/sigmoid_act.sv
// Three-stage sigmoid activation: PLAN approximation of sigmoid(z) plus the
// derivative a*(1-a) for backprop, with a valid/ready handshake on both sides.
module sigmoid_act #(
    parameter int WIDTH = ann_fixed_pkg::WIDTH,
    parameter int FRAC  = ann_fixed_pkg::FRAC
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic signed [WIDTH-1:0] i_z,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic signed [WIDTH-1:0] o_a,
    output logic signed [WIDTH-1:0] o_da
);

    import ann_fixed_pkg::*;

    localparam logic signed [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic        [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

    // |z| without the two's-complement overflow at the most negative value
    function automatic logic [WIDTH-1:0] sat_abs(input logic signed [WIDTH-1:0] z);
        if (z == MIN_NEG)
            return MAX_POS;
        else if (z[WIDTH-1])
            return $unsigned(-z);
        else
            return $unsigned(z);
    endfunction

    function automatic seg_t classify(input logic [WIDTH-1:0] x);
        if (x >= $unsigned(BP_5))
            return SEG_3;
        else if (x >= $unsigned(BP_2375))
            return SEG_2;
        else if (x >= $unsigned(BP_1))
            return SEG_1;
        else
            return SEG_0;
    endfunction

    // Evaluates the curve on |z| and mirrors it about 0.5 for negative inputs
    function automatic logic signed [WIDTH-1:0] pwl(input logic [WIDTH-1:0] x,
                                                    input seg_t seg,
                                                    input logic neg);
        logic [WIDTH-1:0] y;
        case (seg)
            SEG_0:   y = (x >> 2) + $unsigned(Q_HALF);
            SEG_1:   y = (x >> 3) + $unsigned(Q_0625);
            SEG_2:   y = (x >> 5) + $unsigned(Q_084375);
            default: y = $unsigned(ONE);
        endcase
        return neg ? ONE - $signed(y) : $signed(y);
    endfunction

    logic                    adv;
    logic [WIDTH-1:0]        x_in;
    logic signed [WIDTH-1:0] one_m;
    logic signed [WIDTH-1:0] da_next;

    logic                    vld_p0;
    logic                    neg_p0;
    logic [WIDTH-1:0]        x_p0;
    seg_t                    seg_p0;

    logic                    vld_p1;
    logic signed [WIDTH-1:0] a_p1;

    logic                    vld_p2;
    logic signed [WIDTH-1:0] a_p2;
    logic signed [WIDTH-1:0] da_p2;

    assign adv     = !vld_p2 || i_ready;
    assign o_ready = adv;
    assign o_valid = vld_p2;
    assign o_a     = a_p2;
    assign o_da    = da_p2;

    assign x_in  = sat_abs(i_z);
    assign one_m = ONE - a_p1;

    fxp_mult #(
        .WIDTH(WIDTH),
        .FRAC (FRAC)
    ) u_deriv_mult (
        .a(a_p1),
        .b(one_m),
        .p(da_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            neg_p0 <= 1'b0;
            x_p0   <= '0;
            seg_p0 <= SEG_0;
            vld_p1 <= 1'b0;
            a_p1   <= '0;
            vld_p2 <= 1'b0;
            a_p2   <= '0;
            da_p2  <= '0;
        end else if (adv) begin
            // stage 1: sign, magnitude, segment
            vld_p0 <= i_valid;
            neg_p0 <= i_z[WIDTH-1];
            x_p0   <= x_in;
            seg_p0 <= classify(x_in);
            // stage 2: piecewise-linear activation
            vld_p1 <= vld_p0;
            a_p1   <= pwl(x_p0, seg_p0, neg_p0);
            // stage 3: derivative a*(1-a)
            vld_p2 <= vld_p1;
            a_p2   <= a_p1;
            da_p2  <= da_next;
        end
    end

endmodule

// File: tb/tb_sigmoid_act.sv
// Directed bench for sigmoid_act: reset, hand-computed PLAN values, breakpoints,
// backpressure ordering/stability and bubble propagation.
module tb_sigmoid_act;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_z;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_a;
    logic [31:0] o_da;

    int checks;
    int errors;

    logic [31:0] vz  [16];
    logic [31:0] va  [16];
    logic [31:0] vda [16];
    int          nvec;

    sigmoid_act dut (
        .clk    (clk),
        .rst    (rst),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_z    (i_z),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_a    (o_a),
        .o_da   (o_da)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic add_vec(input logic [31:0] z, input logic [31:0] a, input logic [31:0] da);
        vz[nvec]  = z;
        va[nvec]  = a;
        vda[nvec] = da;
        nvec++;
    endtask

    initial begin
        int          sent;
        int          recv;
        logic        acc;
        logic        outx;
        logic        stall;
        logic [31:0] held_a;
        logic [31:0] held_da;
        int          rp [6];
        logic        bub_in  [8];
        logic        bub_out [8];

        checks = 0;
        errors = 0;
        nvec   = 0;
        rp     = '{1, 0, 0, 1, 0, 1};

        add_vec(32'h0000_0000, 32'h0080_0000, 32'h0040_0000);
        add_vec(32'h0100_0000, 32'h00C0_0000, 32'h0030_0000);
        add_vec(32'hFF00_0000, 32'h0040_0000, 32'h0030_0000);
        add_vec(32'h0600_0000, 32'h0100_0000, 32'h0000_0000);
        add_vec(32'hFA00_0000, 32'h0000_0000, 32'h0000_0000);
        add_vec(32'h8000_0000, 32'h0000_0000, 32'h0000_0000);
        add_vec(32'h0260_0000, 32'h00EB_0000, 32'h0013_4700);
        add_vec(32'h0500_0000, 32'h0100_0000, 32'h0000_0000);
        add_vec(32'h00FF_FFFF, 32'h00BF_FFFF, 32'h0030_0000);
        add_vec(32'h0040_0000, 32'h0090_0000, 32'h003F_0000);
        add_vec(32'hFDA0_0000, 32'h0015_0000, 32'h0013_4700);
        add_vec(32'h0300_0000, 32'h00F0_0000, 32'h000F_0000);
        add_vec(32'h7FFF_FFFF, 32'h0100_0000, 32'h0000_0000);
        add_vec(32'h025F_FFFF, 32'h00EB_FFFF, 32'h0012_7000);

        // Power-on reset
        rst     = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_z     = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_o_valid", 32'(o_valid), 32'd0);
        chk("reset_o_a", o_a, 32'd0);
        chk("reset_o_da", o_da, 32'd0);
        chk("reset_o_ready", 32'(o_ready), 32'd1);

        // Reset with two samples in flight
        i_valid = 1'b1;
        i_z     = 32'h0000_0000;
        tick();
        i_z = 32'h0100_0000;
        tick();
        i_valid = 1'b0;
        rst     = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_o_valid", 32'(o_valid), 32'd0);
        chk("midrst_o_a", o_a, 32'd0);
        chk("midrst_o_da", o_da, 32'd0);
        for (int t = 0; t < 5; t++) begin
            tick();
            chk("midrst_no_emerge", 32'(o_valid), 32'd0);
        end

        // Back-to-back directed values, exact 3-clock latency
        for (int t = 0; t < nvec + 2; t++) begin
            i_valid = (t < nvec);
            i_z     = (t < nvec) ? vz[t] : 32'd0;
            tick();
            if (t < 2) begin
                chk("lat_early_valid", 32'(o_valid), 32'd0);
            end else begin
                chk($sformatf("vec%0d_valid", t - 2), 32'(o_valid), 32'd1);
                chk($sformatf("vec%0d_a", t - 2), o_a, va[t - 2]);
                chk($sformatf("vec%0d_da", t - 2), o_da, vda[t - 2]);
            end
        end
        i_valid = 1'b0;
        tick();
        chk("stream_drained", 32'(o_valid), 32'd0);

        // Backpressure: 8 samples, i_ready toggling 1,0,0,1,0,1,...
        sent = 0;
        recv = 0;
        for (int c = 0; c < 80 && recv < 8; c++) begin
            i_ready = rp[c % 6];
            i_valid = (sent < 8);
            i_z     = (sent < 8) ? vz[sent] : 32'd0;
            #1;
            chk("bp_o_ready", 32'(o_ready), 32'(!o_valid || i_ready));
            acc     = i_valid && o_ready;
            outx    = o_valid && i_ready;
            stall   = o_valid && !i_ready;
            held_a  = o_a;
            held_da = o_da;
            if (outx) begin
                chk($sformatf("bp%0d_a", recv), o_a, va[recv]);
                chk($sformatf("bp%0d_da", recv), o_da, vda[recv]);
                recv++;
            end
            tick();
            if (acc) sent++;
            if (stall) begin
                chk("bp_hold_valid", 32'(o_valid), 32'd1);
                chk("bp_hold_a", o_a, held_a);
                chk("bp_hold_da", o_da, held_da);
            end
        end
        chk("bp_sent", 32'(sent), 32'd8);
        chk("bp_received", 32'(recv), 32'd8);
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("bp_no_extra", 32'(o_valid), 32'd0);
        end

        // Bubbles: i_valid 1,0,1,0 gives o_valid 1,0,1,0 three clocks later
        bub_in  = '{1, 0, 1, 0, 0, 0, 0, 0};
        bub_out = '{0, 0, 1, 0, 1, 0, 0, 0};
        for (int t = 0; t < 8; t++) begin
            i_ready = 1'b1;
            i_valid = bub_in[t];
            i_z     = (t == 0) ? vz[0] : vz[1];
            tick();
            chk($sformatf("bubble_valid_t%0d", t), 32'(o_valid), 32'(bub_out[t]));
            if (t == 2) chk("bubble_a0", o_a, va[0]);
            if (t == 4) chk("bubble_a1", o_a, va[1]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sigmoid_act.md
Name: sigmoid_act

Overview:
- Activation stage directly downstream of `perceptron`. It consumes the pre-activation sum z (Q8.24 signed) and produces:
  - the activation a = sigmoid(z), using a shift-only piecewise-linear (PLAN) approximation;
  - the derivative da = a·(1−a), needed by the backprop layer.
- Three-stage pipeline with a valid/ready handshake on both sides. Throughput is 1 sample/cycle when not stalled.

Parameters:
- WIDTH, 32, total fixed-point word width (signed two's complement).
- FRAC, 24, number of fractional bits. ONE = 1<<FRAC.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- i_valid  in  1  upstream sample valid.
- o_ready  out  1  block can accept a sample this cycle.
- i_z  in  WIDTH  pre-activation sum, Q8.24 signed.
- o_valid  out  1  o_a/o_da valid.
- i_ready  in  1  downstream accepts the output this cycle.
- o_a  out  WIDTH  sigmoid(z), Q8.24, range [0, ONE].
- o_da  out  WIDTH  a·(1−a), Q8.24, range [0, ONE/4].

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
  - rst sampled high at a clk edge clears all stage valids.
  - o_valid=0, o_a=0, o_da=0. Pipeline data registers are also cleared to 0.
  - Reset mid-operation discards in-flight samples; no output appears for them.
- Handshake:
  - adv = !o_valid | i_ready; o_ready = adv (combinational).
  - Input transfer when i_valid & o_ready. Output transfer when o_valid & i_ready.
  - When adv=0 every stage holds, data and valid.
  - When adv=1 every stage shifts, with bubbles propagating as valid=0.
  - o_a/o_da hold stable while o_valid=1 and i_ready=0.
- Latency: an accepted sample appears on o_valid exactly 3 adv-cycles later. With i_ready tied high that is 3 clocks.
- Stage 1 (abs/segment):
  - neg = z[WIDTH−1].
  - x = |z|. z = −2^(WIDTH−1) saturates to 2^(WIDTH−1)−1.
  - seg is registered along with neg and x:
    - 3 if x ≥ 5.0;
    - 2 if 2.375 ≤ x < 5.0;
    - 1 if 1.0 ≤ x < 2.375;
    - 0 if x < 1.0.
- Stage 2 (PWL), y for x ≥ 0:
  - seg0: (x>>2) + 0.5
  - seg1: (x>>3) + 0.625
  - seg2: (x>>5) + 0.84375
  - seg3: ONE
  - Shifts are logical on the non-negative x and truncate. Constants are in Q8.24.
  - Output of the stage: a = neg ? ONE − y : y, registered.
- Stage 3 (derivative):
  - one_m = ONE − a.
  - p = a · one_m as a full 2·WIDTH signed product; da = p[FRAC+WIDTH−1 : FRAC] (truncate).
  - a and da are registered to o_a and o_da.
- Width rules:
  - All intermediates are WIDTH bits except the product.
  - No overflow is possible, since a and one_m are in [0, ONE].
- Boundary points belong to the upper segment: exactly 1.0 → seg1, 2.375 → seg2, 5.0 → seg3.

Decomposition:
- Shared fixed-point package `ann_fixed_pkg`:
  - WIDTH, FRAC, ONE;
  - constants Q_HALF, Q_0625, Q_084375;
  - breakpoints BP_1, BP_2375, BP_5.
- One natural sub-module: `fxp_mult` (signed Q8.24 multiply with truncation). It is reused by the perceptron and the backprop blocks.
- The pipeline control stays in `sigmoid_act`.

Test Plan:
- Reset mid-stream: send 2 samples with i_ready=1, assert rst one clock in flight.
  - Required: o_valid=0, o_a=0, o_da=0 next cycle.
  - Required: neither sample ever emerges.
- Basic values, i_ready=1, one per cycle:
  - z=0x00000000 → a=0x00800000, da=0x00400000.
  - z=0x01000000 → a=0x00C00000, da=0x00300000.
  - z=0xFF000000 (−1.0) → a=0x00400000, da=0x00300000.
  - Each output appears exactly 3 clocks after its input.
- Saturation/extremes:
  - z=0x06000000 → a=0x01000000, da=0.
  - z=0xFA000000 → a=0, da=0.
  - z=0x80000000 → a=0, da=0 (no abs overflow).
- Breakpoints:
  - z=0x02600000 (2.375) → a=0x00EB0000.
  - z=0x05000000 → a=0x01000000.
  - z=0x00FFFFFF → seg0 result a=0x00BFFFFF.
- Backpressure: stream 8 back-to-back samples while toggling i_ready 1,0,0,1,0,1…
  - Required: o_ready follows adv.
  - Required: no sample is lost or duplicated, order is preserved, and outputs stay stable while stalled.
- Bubbles: i_valid pattern 1,0,1,0 with i_ready=1 → o_valid pattern 1,0,1,0 delayed by 3 clocks.
